// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage shift execution pipeline with valid/ready handshaking.
//
// Operation select (in_op): 00 SLL, 01 SRL, 10 SRA, 11 PASS (shift amount ignored).
// S1 registers the operand, op and shift amount. The shift is computed
// combinationally from S1, and S2 registers the result and its zero flag.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    upstream presents an operation
//   in_ready    stage can accept an operation this cycle
//               (combinational from out_ready)
//   in_op       operation select
//   in_data     operand, N bits
//   in_shamt    shift amount, 0..N-1
//   out_valid   result present
//   out_ready   downstream accepts the result
//   out_data    shift result, N bits
//   out_zero    high when out_data is zero
//   done_count  completed output transfers, saturating at 0xFFFF
module shift_exec_stage #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_zero,
  output logic [15:0]          done_count
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  function automatic logic signed [N-1:0] shift_op(
    input logic [1:0]           op,
    input logic signed [N-1:0]  d,
    input logic [$clog2(N)-1:0] s
  );
    logic signed [N-1:0] r;
    case (op)
      OP_SLL:  r = d << s;
      OP_SRL:  r = $signed($unsigned(d) >> s);
      OP_SRA:  r = d >>> s;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic                        vld_p1;
  logic [1:0]                  op_p1;
  logic signed [N-1:0]         data_p1;
  logic [$clog2(N)-1:0]        shamt_p1;
  logic signed [N-1:0]         res_p1;

  logic                        vld_p2;
  logic signed [N-1:0]         data_p2;
  logic                        zero_p2;

  logic [15:0]                 cnt_q;

  logic                        s2_take;
  logic                        s1_take;
  logic                        in_xfer;
  logic                        out_xfer;

  // S2 can load whenever it is empty or its result leaves this cycle; S1 can
  // load whenever it is empty or it drains into S2.
  assign s2_take  = !vld_p2 || out_ready;
  assign s1_take  = !vld_p1 || s2_take;
  assign in_ready = s1_take;
  assign in_xfer  = in_valid && s1_take;
  assign out_xfer = vld_p2 && out_ready;

  // ---- stage 1: operand register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      op_p1    <= '0;
      data_p1  <= '0;
      shamt_p1 <= '0;
    end else if (in_xfer) begin
      vld_p1   <= 1'b1;
      op_p1    <= in_op;
      data_p1  <= $signed(in_data);
      shamt_p1 <= in_shamt;
    end else if (s2_take) begin
      vld_p1   <= 1'b0;
    end
  end

  // ---- S1 -> S2: combinational shift ----
  assign res_p1 = shift_op(op_p1, data_p1, shamt_p1);

  // ---- stage 2: result register ----
  // Data only reloads when a valid operand moves up, so a drained S2 keeps
  // presenting its last value with out_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      zero_p2 <= 1'b1;
    end else if (s2_take) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= res_p1;
        zero_p2 <= (res_p1 == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid  = vld_p2;
  assign out_data   = data_p2;
  assign out_zero   = zero_p2;
  assign done_count = cnt_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: randomized and directed bench for shift_exec_stage.
// A behavioural reference computes each result with plain integer arithmetic
// (multiply / floor-divide by powers of two) and tracks pipeline occupancy;
// outputs are compared against it on every falling edge.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_shamt = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_zero;
  logic [15:0] done_count;

  int n_checks;
  int n_fail;

  // reference model state
  logic        m_s1v, m_s2v;
  logic [31:0] m_s1r, m_s2r;
  logic [15:0] m_cnt;
  int          preset_req, preset_seen;

  // observation log written by the compare process
  logic [31:0] obs_d[$];
  logic        obs_z[$];
  int          obs_c[$];
  int          acc_n;
  int          cyc;

  always #5 clk = ~clk;

  shift_exec_stage #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .done_count (done_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of an operation from integer arithmetic on the operand value.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d,
                                             input logic [4:0] s);
    longint p2, v, q, m32;
    logic [63:0] t;
    m32 = 64'h1_0000_0000;
    p2 = 1;
    for (int i = 0; i < int'(s); i++) p2 = p2 * 2;
    v = longint'({32'b0, d});
    case (op)
      2'd0: q = (v * p2) % m32;
      2'd1: q = v / p2;
      2'd2: begin
        if (d[31]) v = v - m32;
        if (v >= 0) q = v / p2;
        else        q = -((-v + p2 - 1) / p2);
      end
      default: q = v;
    endcase
    t = q;
    return t[31:0];
  endfunction

  task automatic model_loop();
    logic rdy, take_in, out_x, adv;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1v = 1'b0;
        m_s2v = 1'b0;
        m_s2r = 32'd0;
        m_cnt = 16'd0;
      end else begin
        if (preset_req != preset_seen) begin
          m_cnt       = 16'hFFFE;
          preset_seen = preset_req;
        end
        rdy     = !(m_s1v && m_s2v) || out_ready;
        take_in = in_valid && rdy;
        out_x   = m_s2v && out_ready;
        adv     = !m_s2v || out_ready;
        if (out_x && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (adv) begin
          if (m_s1v) m_s2r = m_s1r;
          m_s2v = m_s1v;
          m_s1v = 1'b0;
        end
        if (take_in) begin
          m_s1v = 1'b1;
          m_s1r = ref_result(in_op, in_data, in_shamt);
        end
      end
    end
  endtask

  task automatic compare_loop();
    logic exp_ready;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_done_count", 32'(done_count), 32'd0);
      end else begin
        exp_ready = !(m_s1v && m_s2v) || out_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(m_s2v));
        if (m_s2v) begin
          chk("out_data", out_data, m_s2r);
          chk("out_zero", 32'(out_zero), 32'(m_s2r == 32'd0));
        end
        chk("done_count", 32'(done_count), 32'(m_cnt));
        if (out_valid && out_ready) begin
          obs_d.push_back(out_data);
          obs_z.push_back(out_zero);
          obs_c.push_back(cyc);
        end
        if (in_valid && in_ready) acc_n++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic single(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp, input string name);
    int base;
    base      = obs_d.size();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_shamt  = s;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk({name, "_count"}, 32'(obs_d.size() - base), 32'd1);
    if (obs_d.size() > base) begin
      chk(name, obs_d[base], exp);
      chk({name, "_zero"}, 32'(obs_z[base]), 32'(exp == 32'd0));
    end
  endtask

  initial begin
    int base;
    int acc0;
    n_checks = 0; n_fail = 0;
    m_s1v = 1'b0; m_s2v = 1'b0; m_s1r = 32'd0; m_s2r = 32'd0; m_cnt = 16'd0;
    preset_req = 0; preset_seen = 0;
    acc_n = 0; cyc = 0;
    fork
      model_loop();
      compare_loop();
    join_none

    // hand-computed values pinning the reference arithmetic
    chk("ref_sll_1_31", ref_result(2'd0, 32'h00000001, 5'd31), 32'h80000000);
    chk("ref_srl_msb_4", ref_result(2'd1, 32'h80000000, 5'd4), 32'h08000000);
    chk("ref_sra_f_9", ref_result(2'd2, 32'hF0000000, 5'd9), 32'hFFF80000);
    chk("ref_sra_pos_31", ref_result(2'd2, 32'h7FFFFFFF, 5'd31), 32'h00000000);
    chk("ref_pass", ref_result(2'd3, 32'h1234ABCD, 5'd7), 32'h1234ABCD);
    chk("ref_sll_0", ref_result(2'd0, 32'hFFFFFFFF, 5'd0), 32'hFFFFFFFF);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // first operation right after reset release
    single(2'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF, "sra_msb_31");
    chk("first_done_count", 32'(done_count), 32'd1);

    single(2'd1, 32'h80000000, 5'd4,  32'h08000000, "srl_msb_4");
    single(2'd0, 32'h00000001, 5'd31, 32'h80000000, "sll_1_31");
    single(2'd1, 32'h00000001, 5'd1,  32'h00000000, "srl_1_1");
    single(2'd3, 32'h1234ABCD, 5'd7,  32'h1234ABCD, "pass");
    single(2'd2, 32'h40000000, 5'd30, 32'h00000001, "sra_pos_30");
    single(2'd0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, "sll_sh0");

    // back-to-back SRA of 0xF0000000, shamt 0..9 (shamt 9 gives 0xFFF80000)
    base = obs_d.size();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = 2'd2; in_data = 32'hF0000000; in_shamt = 5'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("b2b_count", 32'(obs_d.size() - base), 32'd10);
    if (obs_d.size() >= base + 10) begin
      chk("b2b_first", obs_d[base], 32'hF0000000);
      chk("b2b_mid", obs_d[base+4], 32'hFF000000);
      chk("b2b_last", obs_d[base+9], 32'hFFF80000);
      chk("b2b_span", 32'(obs_c[base+9] - obs_c[base]), 32'd9);
    end

    // backpressure: out_ready low for 5 cycles with in_valid held high
    acc0 = acc_n;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'd3; in_data = 32'h11110000 + 32'(i); in_shamt = 5'd3;
      step();
      if (i >= 1) chk("bp_hold_data", out_data, 32'h11110000);
    end
    chk("bp_accepted", 32'(acc_n - acc0), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    base = obs_d.size();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("bp_drain_count", 32'(obs_d.size() - base), 32'd2);
    if (obs_d.size() >= base + 2) begin
      chk("bp_drain_0", obs_d[base], 32'h11110000);
      chk("bp_drain_1", obs_d[base+1], 32'h11110001);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       in_data = 32'd0;
        1:       in_data = 32'h80000000;
        2:       in_data = 32'hFFFFFFFF;
        default: in_data = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       in_shamt = 5'd0;
        1:       in_shamt = 5'd31;
        default: in_shamt = 5'($urandom_range(0, 31));
      endcase
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // asynchronous reset in the middle of a cycle with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_data = 32'h00000005; in_shamt = 5'd2;
    repeat (3) step();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    base = obs_d.size();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_done_count", 32'(done_count), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_zero", 32'(out_zero), 32'd1);
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("arst_no_stale", 32'(obs_d.size() - base), 32'd0);

    // counter saturation from a preset of 0xFFFE
    out_ready = 1'b0;
    @(negedge clk);
    #1 force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    preset_req++;
    step();
    chk("sat_preset", 32'(done_count), 32'h0000FFFE);
    single(2'd3, 32'h00000001, 5'd0, 32'h00000001, "sat_op1");
    chk("sat_after_1", 32'(done_count), 32'h0000FFFF);
    single(2'd0, 32'h00000003, 5'd1, 32'h00000006, "sat_op2");
    single(2'd1, 32'h00000100, 5'd8, 32'h00000001, "sat_op3");
    chk("sat_after_3", 32'(done_count), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
